rgb_led_pwm_array: RTL

//  Parametrised successor to the 4-LED RGB button controller: drives NUM_LED RGB LEDs by per-colour PWM.

---
 rtl/rgb_led_pwm_array.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rgb_led_pwm_array.sv
// rgb_led_pwm_array: drives NUM_LED RGB LEDs from an 8-entry colour preset
// table selected by edge-detected button presses. Each colour channel has its
// own PWM duty. Modes: STATIC (instant change), FADE (linear ramp toward the
// new colour) and CHASE (one lit LED rotating around the array).
//
// Handshake: there is none. Buttons are level inputs sampled on every rising
// edge; only a 0->1 transition counts as a press.
module rgb_led_pwm_array #(
    parameter int NUM_LED   = 4,
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 1000,
    parameter int CHASE_DIV = 250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         btn,
    input  logic [1:0]         mode,
    output logic [NUM_LED-1:0] led_signal_R,
    output logic [NUM_LED-1:0] led_signal_G,
    output logic [NUM_LED-1:0] led_signal_B,
    output logic               fade_busy,
    output logic [2:0]         sel
);

    typedef enum logic [1:0] {
        MODE_STATIC     = 2'b00,
        MODE_FADE       = 2'b01,
        MODE_CHASE      = 2'b10,
        MODE_STATIC_ALT = 2'b11
    } mode_e;

    localparam int FADE_W  = (FADE_DIV  > 1) ? $clog2(FADE_DIV)  : 1;
    localparam int CHASE_W = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;
    localparam int IDX_W   = (NUM_LED   > 1) ? $clog2(NUM_LED)   : 1;

    localparam logic [PWM_BITS-1:0] MAX        = PWM_BITS'((1 << PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [FADE_W-1:0]   FADE_LAST  = FADE_W'(FADE_DIV - 1);
    localparam logic [CHASE_W-1:0]  CHASE_LAST = CHASE_W'(CHASE_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_LED - 1);

    // Channel index 0 = red, 1 = green, 2 = blue.
    logic [7:0]                    btn_prev_q, btn_prev_d;
    logic                          armed_q, armed_d;
    logic [2:0]                    sel_q, sel_d;
    logic [2:0][PWM_BITS-1:0]      tgt_q, tgt_d;
    logic [2:0][PWM_BITS-1:0]      cur_q, cur_d;
    logic [2:0][PWM_BITS-1:0]      act_q, act_d;
    logic [PWM_BITS-1:0]           pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0]             fade_cnt_q, fade_cnt_d;
    logic [CHASE_W-1:0]            chase_cnt_q, chase_cnt_d;
    logic [IDX_W-1:0]              chase_idx_q, chase_idx_d;
    logic                          chase_mode_q, chase_mode_d;
    logic [2:0][NUM_LED-1:0]       led_q, led_d;

    mode_e               mode_dec;
    logic                is_fade, is_chase;
    logic [7:0]          press;
    logic                hit;
    logic [2:0]          hit_idx;
    logic [2:0]          rgb;
    logic [NUM_LED-1:0]  mask;

    // Preset colour as {R,G,B} on/off bits.
    function automatic logic [2:0] preset_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    preset_rgb = 3'b100;
            3'd1:    preset_rgb = 3'b010;
            3'd2:    preset_rgb = 3'b001;
            3'd3:    preset_rgb = 3'b110;
            3'd4:    preset_rgb = 3'b011;
            3'd5:    preset_rgb = 3'b101;
            3'd6:    preset_rgb = 3'b111;
            default: preset_rgb = 3'b000;
        endcase
    endfunction

    // One fade step of a single channel toward its target.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] c,
                                                        input logic [PWM_BITS-1:0] t);
        if (c < t)      step_toward = c + 1'b1;
        else if (c > t) step_toward = c - 1'b1;
        else            step_toward = c;
    endfunction

    // Next-state logic: press detect, colour targets, fade, PWM and chase.
    always_comb begin
        mode_dec     = mode_e'(mode);
        is_fade      = (mode_dec == MODE_FADE);
        is_chase     = (mode_dec == MODE_CHASE);

        btn_prev_d   = btn;
        armed_d      = 1'b1;
        sel_d        = sel_q;
        tgt_d        = tgt_q;
        cur_d        = cur_q;
        act_d        = act_q;
        pwm_cnt_d    = pwm_cnt_q + 1'b1;
        fade_cnt_d   = '0;
        chase_cnt_d  = '0;
        chase_idx_d  = '0;
        chase_mode_d = is_chase;
        mask         = '1;
        hit          = 1'b0;
        hit_idx      = 3'd0;
        rgb          = 3'b000;

        // A button already held when reset releases is not treated as a press.
        press = armed_q ? (btn & ~btn_prev_q) : 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (press[i]) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
        if (hit) begin
            sel_d    = hit_idx;
            rgb      = preset_rgb(hit_idx);
            tgt_d[0] = rgb[2] ? MAX : '0;
            tgt_d[1] = rgb[1] ? MAX : '0;
            tgt_d[2] = rgb[0] ? MAX : '0;
        end

        // A press restarts the step timer so a full ramp takes exactly
        // MAX*FADE_DIV cycles from the press; outside FADE current follows
        // target one cycle later.
        if (is_fade) begin
            if (hit) begin
                fade_cnt_d = '0;
            end else if (fade_cnt_q == FADE_LAST) begin
                fade_cnt_d = '0;
                for (int ch = 0; ch < 3; ch++) begin
                    cur_d[ch] = step_toward(cur_q[ch], tgt_q[ch]);
                end
            end else begin
                fade_cnt_d = fade_cnt_q + 1'b1;
            end
        end else begin
            cur_d = tgt_q;
        end

        // Duty is only taken over at the period boundary to avoid glitches.
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d = '0;
            act_d     = cur_q;
        end

        // Chase position; cleared on the edge that enters CHASE.
        if (is_chase && chase_mode_q) begin
            chase_idx_d = chase_idx_q;
            if (chase_cnt_q == CHASE_LAST) begin
                chase_idx_d = (chase_idx_q == IDX_LAST) ? '0 : chase_idx_q + 1'b1;
            end else begin
                chase_cnt_d = chase_cnt_q + 1'b1;
            end
        end
        if (is_chase) begin
            for (int k = 0; k < NUM_LED; k++) begin
                mask[k] = (chase_idx_d == IDX_W'(k));
            end
        end

        // Outputs registered against the next counter/duty so they line up.
        for (int ch = 0; ch < 3; ch++) begin
            led_d[ch] = (pwm_cnt_d < act_d[ch]) ? mask : '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_prev_q   <= '0;
            armed_q      <= 1'b0;
            sel_q        <= 3'd7;
            tgt_q        <= '0;
            cur_q        <= '0;
            act_q        <= '0;
            pwm_cnt_q    <= '0;
            fade_cnt_q   <= '0;
            chase_cnt_q  <= '0;
            chase_idx_q  <= '0;
            chase_mode_q <= 1'b0;
            led_q        <= '0;
        end else begin
            btn_prev_q   <= btn_prev_d;
            armed_q      <= armed_d;
            sel_q        <= sel_d;
            tgt_q        <= tgt_d;
            cur_q        <= cur_d;
            act_q        <= act_d;
            pwm_cnt_q    <= pwm_cnt_d;
            fade_cnt_q   <= fade_cnt_d;
            chase_cnt_q  <= chase_cnt_d;
            chase_idx_q  <= chase_idx_d;
            chase_mode_q <= chase_mode_d;
            led_q        <= led_d;
        end
    end

    assign led_signal_R = led_q[0];
    assign led_signal_G = led_q[1];
    assign led_signal_B = led_q[2];
    assign sel          = sel_q;
    assign fade_busy    = (cur_q[0] != tgt_q[0]) | (cur_q[1] != tgt_q[1]) |
                          (cur_q[2] != tgt_q[2]);

endmodule
